// File: rtl/integrator_dump.sv
// integrator_dump -- cascade of K signed integrator stages with sample-valid
// qualification. The block runs free (DUMP=0) or in integrate-and-dump mode
// (DUMP=1). In integrate-and-dump mode the block emits the last stage and
// clears every accumulator once every R accepted samples.
//
// Optional build macro: INTEGRATOR_DUMP_SATURATE_EN
//   When defined, every stage addition saturates instead of wrapping, and a
//   sticky `ovf` output is added.
//
// Parameters: N input width, M accumulator/output width (N<=M<=64),
//             K stages (1..4), DUMP mode, R dump period (2..65536).
// Ports:
//   clk        clock, posedge
//   clr        async reset, active-low
//   sclr       sync clear, active-high (wins over in_valid)
//   in_valid   qualifies `in`
//   in [N]     signed sample
//   out [M]    signed result register, holds between out_valid pulses
//   out_valid  one-cycle pulse when out is updated
//   beat [BW]  accepted-sample counter within the dump period (0 when DUMP=0)
//   ovf        sticky saturation flag (macro builds only)

module integrator_dump_stage #(
    parameter int M = 24
) (
    input  logic signed [M-1:0] i_acc,
    input  logic signed [M-1:0] i_add,
    output logic signed [M-1:0] o_nxt
`ifdef INTEGRATOR_DUMP_SATURATE_EN
   ,output logic                o_sat
`endif
);
`ifdef INTEGRATOR_DUMP_SATURATE_EN
    localparam logic signed [M-1:0] SMAX = {1'b0, {(M-1){1'b1}}};
    localparam logic signed [M-1:0] SMIN = ~SMAX;
    logic signed [M:0] w_wide;

    // One guard bit: the top two bits differ exactly when the M-bit sum overflowed.
    assign w_wide = (M+1)'(i_acc) + (M+1)'(i_add);
    assign o_sat  = w_wide[M] ^ w_wide[M-1];
    assign o_nxt  = o_sat ? (w_wide[M] ? SMIN : SMAX) : w_wide[M-1:0];
`else
    assign o_nxt = i_acc + i_add;
`endif
endmodule

module integrator_dump #(
    parameter  int N    = 16,
    parameter  int M    = 24,
    parameter  int K    = 1,
    parameter  int DUMP = 0,
    parameter  int R    = 8,
    localparam int BW   = (DUMP != 0) ? $clog2(R) : 1
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                sclr,
    input  logic                in_valid,
    input  logic signed [N-1:0] in,
    output logic signed [M-1:0] out,
    output logic                out_valid,
    output logic [BW-1:0]       beat
`ifdef INTEGRATOR_DUMP_SATURATE_EN
   ,output logic                ovf
`endif
);
    localparam logic [BW-1:0] BEAT_LAST = BW'(R - 1);

    logic signed [M-1:0] r_acc    [K];
    logic signed [M-1:0] w_addend [K];
    logic signed [M-1:0] w_nxt    [K];
    logic signed [M-1:0] w_in_ext;
    logic signed [M-1:0] r_out;
    logic                r_vld;
    logic [BW-1:0]       r_beat;
    logic                w_dump;
    logic                w_clear;
`ifdef INTEGRATOR_DUMP_SATURATE_EN
    logic [K-1:0]        w_sat;
    logic                r_ovf;
`endif

    // Signed size cast sign-extends the sample to accumulator width.
    assign w_in_ext = M'(in);

    // Stage i adds the pre-edge value of stage i-1, so the cascade skews by
    // one sample per stage.
    always_comb begin
        w_addend[0] = w_in_ext;
        for (int i = 1; i < K; i++) w_addend[i] = r_acc[i-1];
    end

    for (genvar g = 0; g < K; g++) begin : g_stage
        integrator_dump_stage #(.M(M)) u_stage (
            .i_acc (r_acc[g]),
            .i_add (w_addend[g]),
            .o_nxt (w_nxt[g])
`ifdef INTEGRATOR_DUMP_SATURATE_EN
           ,.o_sat (w_sat[g])
`endif
        );
    end

    // Free-running mode emits on every accepted sample; dump mode emits on the
    // last beat of the period and restarts every accumulator from zero.
    assign w_dump  = (DUMP == 0) || (r_beat == BEAT_LAST);
    assign w_clear = (DUMP != 0) && w_dump;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int k = 0; k < K; k++) r_acc[k] <= '0;
            r_out  <= '0;
            r_vld  <= 1'b0;
            r_beat <= '0;
`ifdef INTEGRATOR_DUMP_SATURATE_EN
            r_ovf  <= 1'b0;
`endif
        end else if (sclr) begin
            for (int k = 0; k < K; k++) r_acc[k] <= '0;
            r_out  <= '0;
            r_vld  <= 1'b0;
            r_beat <= '0;
`ifdef INTEGRATOR_DUMP_SATURATE_EN
            r_ovf  <= 1'b0;
`endif
        end else if (in_valid) begin
            for (int k = 0; k < K; k++) r_acc[k] <= w_clear ? '0 : w_nxt[k];
            r_vld <= w_dump;
            if (w_dump) r_out <= w_nxt[K-1];
            if (DUMP != 0) r_beat <= w_dump ? '0 : r_beat + 1'b1;
`ifdef INTEGRATOR_DUMP_SATURATE_EN
            r_ovf <= r_ovf | (|w_sat);
`endif
        end else begin
            r_vld <= 1'b0;
        end
    end

    assign out       = r_out;
    assign out_valid = r_vld;
    assign beat      = r_beat;
`ifdef INTEGRATOR_DUMP_SATURATE_EN
    assign ovf       = r_ovf;
`endif
endmodule

// File: tb/tb_integrator_dump.sv
// Bench for integrator_dump: four configurations share clock and reset.
//   u0 K=1 free-running, u1 K=1 dump R=4, u2 K=2 free-running, u3 M=N=16.
// Expected outputs are queued when a sample is driven. A negedge monitor pops
// and compares them whenever out_valid pulses.
module tb_integrator_dump;
    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic               sc0 = 0, v0 = 0, sc1 = 0, v1 = 0, sc2 = 0, v2 = 0, sc3 = 0, v3 = 0;
    logic signed [15:0] i0 = 0, i1 = 0, i2 = 0, i3 = 0;
    logic signed [23:0] o0, o1, o2;
    logic signed [15:0] o3;
    logic               ov0, ov1, ov2, ov3;
    logic               b0, b2, b3;
    logic [1:0]         b1;
`ifdef INTEGRATOR_DUMP_SATURATE_EN
    logic               f0, f1, f2, f3;
`endif

    integrator_dump #(.N(16), .M(24), .K(1), .DUMP(0)) u0 (
        .clk(clk), .clr(clr), .sclr(sc0), .in_valid(v0), .in(i0),
        .out(o0), .out_valid(ov0), .beat(b0)
`ifdef INTEGRATOR_DUMP_SATURATE_EN
       ,.ovf(f0)
`endif
    );
    integrator_dump #(.N(16), .M(24), .K(1), .DUMP(1), .R(4)) u1 (
        .clk(clk), .clr(clr), .sclr(sc1), .in_valid(v1), .in(i1),
        .out(o1), .out_valid(ov1), .beat(b1)
`ifdef INTEGRATOR_DUMP_SATURATE_EN
       ,.ovf(f1)
`endif
    );
    integrator_dump #(.N(16), .M(24), .K(2), .DUMP(0)) u2 (
        .clk(clk), .clr(clr), .sclr(sc2), .in_valid(v2), .in(i2),
        .out(o2), .out_valid(ov2), .beat(b2)
`ifdef INTEGRATOR_DUMP_SATURATE_EN
       ,.ovf(f2)
`endif
    );
    integrator_dump #(.N(16), .M(16), .K(1), .DUMP(0)) u3 (
        .clk(clk), .clr(clr), .sclr(sc3), .in_valid(v3), .in(i3),
        .out(o3), .out_valid(ov3), .beat(b3)
`ifdef INTEGRATOR_DUMP_SATURATE_EN
       ,.ovf(f3)
`endif
    );

    longint q0[$], q1[$], q2[$], q3[$];

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: out_valid pulse with no expected result queued", nm);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (ov0) begin if (q0.size() == 0) unexpected("u0"); else check("u0 sb out", longint'(o0), q0.pop_front()); end
        if (ov1) begin if (q1.size() == 0) unexpected("u1"); else check("u1 sb out", longint'(o1), q1.pop_front()); end
        if (ov2) begin if (q2.size() == 0) unexpected("u2"); else check("u2 sb out", longint'(o2), q2.pop_front()); end
        if (ov3) begin if (q3.size() == 0) unexpected("u3"); else check("u3 sb out", longint'(o3), q3.pop_front()); end
    end

    typedef struct {
        logic v;
        int   din;
        int   exp_out;
    } row_t;

    row_t t0[6];
    int   e2[4];

    initial begin
        t0[0] = '{1'b1,   100,   100};
        t0[1] = '{1'b1,   200,   300};
        t0[2] = '{1'b1,   -50,   250};
        t0[3] = '{1'b0,   999,   250};
        t0[4] = '{1'b1, -1000,  -750};
        t0[5] = '{1'b0,     0,  -750};
        e2    = '{0, 1, 3, 6};

        // Reset state while clr is held low
        #12;
        check("rst u0 out", longint'(o0), 0);
        check("rst u0 out_valid", longint'(ov0), 0);
        check("rst u1 beat", longint'(b1), 0);
        check("rst u1 out", longint'(o1), 0);
        check("rst u3 out", longint'(o3), 0);
        @(negedge clk);
        clr = 1'b1;

        // Free-running, K=1: table-driven
        for (int i = 0; i < 6; i++) begin
            v0 = t0[i].v;
            i0 = 16'(t0[i].din);
            if (t0[i].v) q0.push_back(longint'(t0[i].exp_out));
            @(negedge clk);
            check("u0 tbl out", longint'(o0), longint'(t0[i].exp_out));
        end
        v0 = 0;
        check("u0 beat tied", longint'(b0), 0);

        // Dump mode R=4, samples 1..8 every other clock
        for (int s = 1; s <= 8; s++) begin
            v1 = 1; i1 = 16'(s);
            if (s == 4) q1.push_back(10);
            if (s == 8) q1.push_back(26);
            @(negedge clk);
            check("u1 beat", longint'(b1), longint'(s % 4));
            v1 = 0;
            @(negedge clk);
            check("u1 beat idle", longint'(b1), longint'(s % 4));
            check("u1 out hold", longint'(o1), (s < 4) ? 0 : (s < 8) ? 10 : 26);
        end

        // K=2 skew: constant 1
        for (int k = 0; k < 4; k++) begin
            v2 = 1; i2 = 1;
            q2.push_back(longint'(e2[k]));
            @(negedge clk);
            check("u2 skew out", longint'(o2), longint'(e2[k]));
        end
        v2 = 0;

        // Async reset mid-period at beat=2
        for (int s = 0; s < 2; s++) begin
            v1 = 1; i1 = 1;
            @(negedge clk);
        end
        v1 = 0;
        check("u1 pre-rst beat", longint'(b1), 2);
        check("u1 pre-rst out", longint'(o1), 26);
        #2 clr = 1'b0;
        #1;
        check("async u1 beat", longint'(b1), 0);
        check("async u1 out", longint'(o1), 0);
        check("async u1 out_valid", longint'(ov1), 0);
        check("async u2 out", longint'(o2), 0);
        @(negedge clk);
        clr = 1'b1;
        for (int s = 1; s <= 4; s++) begin
            v1 = 1; i1 = 2;
            if (s == 4) q1.push_back(8);
            @(negedge clk);
            check("u1 post-rst beat", longint'(b1), longint'(s % 4));
        end
        v1 = 0;

        // sclr beats a simultaneous sample
        v0 = 1; i0 = 500; q0.push_back(500);
        @(negedge clk);
        sc0 = 1; v0 = 1; i0 = 123;
        @(negedge clk);
        sc0 = 0; v0 = 0;
        check("u0 sclr out", longint'(o0), 0);
        check("u0 sclr out_valid", longint'(ov0), 0);
        v0 = 1; i0 = 7; q0.push_back(7);
        @(negedge clk);
        v0 = 0;
        check("u0 after sclr", longint'(o0), 7);

        v1 = 1; i1 = 3;
        @(negedge clk);
        sc1 = 1;
        @(negedge clk);
        sc1 = 0; v1 = 0;
        check("u1 sclr beat", longint'(b1), 0);
        check("u1 sclr out", longint'(o1), 0);

        // Overflow at M=N=16
        v3 = 1; i3 = 16'sd32767; q3.push_back(32767);
        @(negedge clk);
        i3 = 1;
`ifdef INTEGRATOR_DUMP_SATURATE_EN
        q3.push_back(32767);
`else
        q3.push_back(-32768);
`endif
        @(negedge clk);
        v3 = 0;
`ifdef INTEGRATOR_DUMP_SATURATE_EN
        check("u3 sat out", longint'(o3), 32767);
        check("u3 ovf set", longint'(f3), 1);
        @(negedge clk);
        check("u3 ovf sticky", longint'(f3), 1);
        sc3 = 1;
        @(negedge clk);
        sc3 = 0;
        check("u3 ovf cleared", longint'(f3), 0);
        check("u0 ovf quiet", longint'(f0), 0);
        check("u1 ovf quiet", longint'(f1), 0);
        check("u2 ovf quiet", longint'(f2), 0);
`else
        check("u3 wrap out", longint'(o3), -32768);
`endif

        @(negedge clk);
        check("q0 drained", longint'(q0.size()), 0);
        check("q1 drained", longint'(q1.size()), 0);
        check("q2 drained", longint'(q2.size()), 0);
        check("q3 drained", longint'(q3.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/integrator_dump.md
Name: integrator_dump

Overview:
- Parametrised successor to the single-stage signed integrator.
- Cascades K integrator stages with sample-valid qualification.
- Two modes: free-running, where every accepted sample updates the output, and integrate-and-dump, where the output is emitted and the accumulators are cleared every R accepted samples.
- Sits between ADC/PDM front-ends and decimation or CIC comb sections in the signal path.

Parameters:
- N, 16, input sample width (signed).
- M, 24, accumulator and output width (signed). Constraint: N <= M <= 64.
- K, 1, number of cascaded integrator stages (1..4).
- DUMP, 0, mode select. 0 = free-running, 1 = integrate-and-dump.
- R, 8, dump period in accepted samples (2..65536). Ignored when DUMP=0.

Ports:
- clk  in  1  clock; all state changes on posedge.
- clr  in  1  asynchronous reset, active-low. Asserted (0) forces all state to reset values immediately.
- sclr  in  1  synchronous clear, active-high.
- in_valid  in  1  qualifies in for one cycle.
- in  in  N  signed input sample.
- out  out  M  signed result register.
- out_valid  out  1  one-cycle pulse; out updated this cycle.
- beat  out  clog2(R)  dump-period sample counter. Width 1 when DUMP=0; tied to 0 when DUMP=0.

Behaviour:
- Reset (clr=0, async): acc[0..K-1]=0, out=0, out_valid=0, beat=0. Release is synchronous to the next posedge.
- Arithmetic: in is sign-extended to M bits. All sums are M-bit two's complement. Without SATURATE_EN, overflow wraps modulo 2^M.
- Priority per posedge (clr=1): sclr > in_valid > idle.
- sclr=1: acc all 0, out=0, out_valid=0, beat=0. A simultaneous in_valid sample is discarded.
- Idle (in_valid=0, sclr=0): all state holds; out_valid=0.
- Accepted sample (in_valid=1):
  - acc[0] <= acc[0] + in.
  - acc[i] <= acc[i] + acc[i-1] for i=1..K-1, using pre-edge values. This gives K-1 samples of pipeline skew through the cascade.
  - Define nxt = next value of acc[K-1].
- DUMP=0: out <= nxt, out_valid <= 1 in the same edge. Latency is 1 clk from in_valid to out_valid. Back-to-back in_valid gives back-to-back out_valid.
- DUMP=1, beat < R-1: acc updated as above, beat <= beat+1, out holds, out_valid <= 0.
- DUMP=1, beat == R-1 (dump beat): out <= nxt, out_valid <= 1, every acc <= 0, beat <= 0. Dump output includes the dump-beat sample at stage 0 (exact for K=1). For K>1 the cascade skew applies and contributions still in lower stages are discarded.
- out holds its value between out_valid pulses.
- Gaps in in_valid stretch the period. beat counts accepted samples, not clocks.
- Reset mid-period: all partial sums are lost; the next period starts at beat=0.

Optional Feature:
- Macro: INTEGRATOR_DUMP_SATURATE_EN.
- Defined:
  - Every stage addition saturates to [-2^(M-1), 2^(M-1)-1] instead of wrapping.
  - Adds output port `ovf` (1 bit, sticky). It is set on any edge where any stage saturated, and is cleared only by clr=0 or sclr=1.
  - Saturated values feed later stages unchanged.
- Undefined: wrap-around arithmetic, no `ovf` port, no saturation logic synthesised.

Test Plan:
- K=1, DUMP=0, N=16, M=24: clr pulse low, then in_valid=1 with in=100,200,-50 on consecutive clks -> out=100,300,250, out_valid high on each of the three following clks; out=0 after reset.
- K=1, DUMP=1, R=4: in=1,2,3,4,5 with in_valid every other clk -> single out_valid pulse after the 4th sample with out=10. beat returns to 0; acc restarts so that a 5th-sample-only dump path would yield 5.
- K=2, DUMP=0: constant in=1 for 4 beats -> out=0,1,3,6, showing the 1-sample stage skew.
- Wrap (macro undefined), M=N=16, K=1: acc=32767 then in=1 -> out=-32768, no ovf port. With INTEGRATOR_DUMP_SATURATE_EN: out=32767, ovf=1 and remains 1 until sclr.
- sclr and in_valid both high with acc=500 -> out=0, out_valid=0, beat=0, sample dropped. Next in=7 -> out=7.
- Async reset mid-period: assert clr=0 between clock edges at beat=2 -> out, out_valid and beat read 0 before the next posedge; after release, a full R samples are needed for the next dump.
